bench_sequencer: RTL and testbench
==================================

# bench_sequencer

Parametrised benchmark controller for PQC arithmetic cores. It sits between the UART byte receiver/transmitter and a variable-latency compute unit. A host configures the iteration count and sends a multi-byte seed. The block runs the unit in a closed feedback loop for N iterations and returns the multi-byte result, plus a cycle count when the cycle report is compiled in.

## Interface
- DATA_W, 32, operand/result width in bits; multiple of 8, 8..256
- CNT_W, 32, iteration counter width in bits; multiple of 8, 8..32
- DEFAULT_ITER, 5000000, iteration count loaded at reset; must fit in CNT_W
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- rx_data  in  8  received byte
- rx_ready  in  1  one-cycle strobe; rx_data valid this cycle
- tx_data  out  8  byte to transmit; reset 0
- tx_start  out  1  one-cycle transmit strobe; reset 0
- tx_busy  in  1  transmitter busy
- dut_start  out  1  one-cycle operation strobe to compute unit; reset 0
- dut_din  out  DATA_W  operand, held stable from dut_start until dut_done; reset 0
- dut_dout  in  DATA_W  unit result, valid when dut_done=1
- dut_done  in  1  one-cycle completion strobe, at least 1 cycle after dut_start
- led  out  1  high only in ISSUE/WAIT (computation active); reset 0

## Operation
- Byte counts: SB = DATA_W/8 seed/result bytes; CB = CNT_W/8 count bytes. All multi-byte fields are little-endian.
- Command 0x4E ('N') + CB bytes: sets iter_limit. It takes effect on the next run.
- Command 0x53 ('S') + SB bytes: loads the seed into register a, clears the iteration and cycle counters, and starts a run.
- Any other byte in IDLE is ignored. Bytes arriving outside IDLE/ARG are dropped.
- States and transitions:
  - IDLE: on rx_ready with a valid command, go to ARG.
  - ARG: collect bytes into a shift register. After the last byte, an N command returns to IDLE; an S command goes to ISSUE.
  - ISSUE: if iter == iter_limit, go to TX_LOAD. Otherwise drive dut_din = a, pulse dut_start, and go to WAIT.
  - WAIT: on dut_done, set a <= dut_dout + 1 (mod 2^DATA_W) and iter <= iter + 1, then go to ISSUE.
  - TX_LOAD: when tx_busy=0, drive tx_data with the next byte, pulse tx_start, and go to TX_WAIT.
  - TX_WAIT: wait for tx_busy=1, then tx_busy=0. If more bytes remain, go to TX_LOAD; else go to IDLE.
- Response: SB bytes of a, LSB first.
- iter_limit = 0: no dut_start is issued, and the response equals the seed.
- Cycle counter: 32 bits. It increments every cycle in ISSUE/WAIT and saturates at 0xFFFFFFFF.
- rst at any time: the FSM returns to IDLE, all outputs go to their reset values, iter_limit = DEFAULT_ITER, and a partial command is discarded.
- dut_done outside WAIT is ignored.

## Timing
- rx_ready of the final argument byte → ISSUE on the next cycle; dut_start on the cycle after that.
- Per iteration: the cost is the unit latency L plus 1 cycle (ISSUE). Total compute time = N·(L+1) + 1 cycles.
- dut_done → a updated on the same clock edge; the next dut_start follows 1 cycle later.
- tx_start is high exactly 1 cycle per byte. tx_data is stable from tx_start until the next TX_LOAD.
- The transmitter must raise tx_busy within 2 cycles of tx_start.

## Configuration
- CYCLE_REPORT_EN defined: after the SB result bytes, transmit 4 cycle-counter bytes, LSB first (SB+4 bytes total).
- CYCLE_REPORT_EN undefined: the cycle counter is not built, and the response is SB bytes only.

## Test plan
- DATA_W=32, N default overridden to 3 via 'N' 03 00 00 00; DUT model returns din·2 with L=4; seed 01 00 00 00. Expected: a goes 1→3→7→15; response 0F 00 00 00; with CYCLE_REPORT_EN, cycles = 16 → 10 00 00 00.
- 'N' 00 00 00 00, then 'S' AA BB CC DD → response AA BB CC DD; no dut_start pulse observed.
- Wrap-around: DUT model is identity, seed FF FF FF FF, N=1 → response 00 00 00 00.
- Bytes 0x53 (the second 'S') and 0x11 sent during WAIT are dropped; the run completes with the unchanged result; the next command is accepted normally.
- rst asserted mid-WAIT and mid-ARG: the FSM returns to IDLE, led=0, tx_start=0; iter_limit reverts to DEFAULT_ITER (confirmed by a following run with the identity DUT and a dut_start count of 5000000 → shorten DEFAULT_ITER=5 in this bench).
- Invalid byte 0x7F in IDLE is ignored; tx_busy held high for 50 cycles delays the first tx_start until it falls.

Source files
------------

// File: rtl/bench_sequencer.sv
// UART-driven benchmark controller: runs a compute unit in a closed a <- f(a)+1 loop for N iterations.
// Optional macro CYCLE_REPORT_EN appends a saturating 32-bit ISSUE/WAIT cycle count to each response.
module bench_sequencer #(
  parameter int DATA_W       = 32,
  parameter int CNT_W        = 32,
  parameter int DEFAULT_ITER = 5000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              dut_start,
  output logic [DATA_W-1:0] dut_din,
  input  logic [DATA_W-1:0] dut_dout,
  input  logic              dut_done,
  output logic              led
);
  localparam int SB    = DATA_W / 8;
  localparam int CB    = CNT_W / 8;
  localparam int ARG_W = (DATA_W > CNT_W) ? DATA_W : CNT_W;
`ifdef CYCLE_REPORT_EN
  localparam int TX_W  = DATA_W + 32;
`else
  localparam int TX_W  = DATA_W;
`endif
  localparam int TX_BYTES = TX_W / 8;

  typedef enum logic [2:0] {S_IDLE, S_ARG, S_ISSUE, S_WAIT, S_TX_LOAD, S_TX_WAIT} state_t;

  state_t            state_q, state_d;
  logic [ARG_W-1:0]  arg_q, arg_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              is_seed_q, is_seed_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [CNT_W-1:0]  iter_q, iter_d;
  logic [CNT_W-1:0]  limit_q, limit_d;
  logic [TX_W-1:0]   txsr_q, txsr_d;
  logic              busy_seen_q, busy_seen_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_start_q, tx_start_d;
  logic              dut_start_q, dut_start_d;
  logic [DATA_W-1:0] dut_din_q, dut_din_d;
  logic              led_q, led_d;
`ifdef CYCLE_REPORT_EN
  logic [31:0]       cyc_q, cyc_d;
`endif

  always_comb begin
    state_d     = state_q;
    arg_d       = arg_q;
    cnt_d       = cnt_q;
    is_seed_d   = is_seed_q;
    a_d         = a_q;
    iter_d      = iter_q;
    limit_d     = limit_q;
    txsr_d      = txsr_q;
    busy_seen_d = busy_seen_q;
    tx_data_d   = tx_data_q;
    tx_start_d  = 1'b0;
    dut_start_d = 1'b0;
    dut_din_d   = dut_din_q;
`ifdef CYCLE_REPORT_EN
    cyc_d = cyc_q;
    if ((state_q == S_ISSUE || state_q == S_WAIT) && cyc_q != 32'hFFFF_FFFF) begin
      cyc_d = cyc_q + 32'd1;
    end
`endif
    case (state_q)
      S_IDLE: begin
        if (rx_ready && (rx_data == 8'h4E || rx_data == 8'h53)) begin
          is_seed_d = (rx_data == 8'h53);
          cnt_d     = (rx_data == 8'h53) ? 8'(SB) : 8'(CB);
          state_d   = S_ARG;
        end
      end
      S_ARG: begin
        if (rx_ready) begin
          // Little-endian: each byte enters at the top, so the field ends up MSB-aligned.
          arg_d = ARG_W'({rx_data, arg_q} >> 8);
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            if (is_seed_q) begin
              a_d     = arg_d[ARG_W-1 -: DATA_W];
              iter_d  = '0;
`ifdef CYCLE_REPORT_EN
              cyc_d   = '0;
`endif
              state_d = S_ISSUE;
            end else begin
              limit_d = arg_d[ARG_W-1 -: CNT_W];
              state_d = S_IDLE;
            end
          end
        end
      end
      S_ISSUE: begin
        if (iter_q == limit_q) begin
          // cyc_d already includes this final ISSUE cycle.
`ifdef CYCLE_REPORT_EN
          txsr_d = {cyc_d, a_q};
`else
          txsr_d = a_q;
`endif
          cnt_d   = 8'(TX_BYTES);
          state_d = S_TX_LOAD;
        end else begin
          dut_din_d   = a_q;
          dut_start_d = 1'b1;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (dut_done) begin
          a_d     = dut_dout + DATA_W'(1);
          iter_d  = iter_q + CNT_W'(1);
          state_d = S_ISSUE;
        end
      end
      S_TX_LOAD: begin
        if (!tx_busy) begin
          tx_data_d   = txsr_q[7:0];
          txsr_d      = txsr_q >> 8;
          cnt_d       = cnt_q - 8'd1;
          tx_start_d  = 1'b1;
          busy_seen_d = 1'b0;
          state_d     = S_TX_WAIT;
        end
      end
      S_TX_WAIT: begin
        if (tx_busy) begin
          busy_seen_d = 1'b1;
        end else if (busy_seen_q) begin
          state_d = (cnt_q == 8'd0) ? S_IDLE : S_TX_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase
    led_d = (state_d == S_ISSUE) || (state_d == S_WAIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      arg_q       <= '0;
      cnt_q       <= '0;
      is_seed_q   <= 1'b0;
      a_q         <= '0;
      iter_q      <= '0;
      limit_q     <= CNT_W'(DEFAULT_ITER);
      txsr_q      <= '0;
      busy_seen_q <= 1'b0;
      tx_data_q   <= '0;
      tx_start_q  <= 1'b0;
      dut_start_q <= 1'b0;
      dut_din_q   <= '0;
      led_q       <= 1'b0;
`ifdef CYCLE_REPORT_EN
      cyc_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      arg_q       <= arg_d;
      cnt_q       <= cnt_d;
      is_seed_q   <= is_seed_d;
      a_q         <= a_d;
      iter_q      <= iter_d;
      limit_q     <= limit_d;
      txsr_q      <= txsr_d;
      busy_seen_q <= busy_seen_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      dut_start_q <= dut_start_d;
      dut_din_q   <= dut_din_d;
      led_q       <= led_d;
`ifdef CYCLE_REPORT_EN
      cyc_q       <= cyc_d;
`endif
    end
  end

  assign tx_data   = tx_data_q;
  assign tx_start  = tx_start_q;
  assign dut_start = dut_start_q;
  assign dut_din   = dut_din_q;
  assign led       = led_q;

endmodule

// File: tb/tb_bench_sequencer.sv
// Bench for bench_sequencer: directed and randomized runs against an iteration-level reference model.
module tb_bench_sequencer;
`ifdef CYCLE_REPORT_EN
  localparam int RESP_B = 8;
`else
  localparam int RESP_B = 4;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic        dut_start;
  logic [31:0] dut_din;
  logic [31:0] dut_dout = 32'h0;
  logic        dut_done = 1'b0;
  logic        led;

  logic        hold_busy = 1'b0;
  logic        tx_act = 1'b0;
  int          tx_left = 0;
  int          tx_total = 0;
  logic [7:0]  txlog [0:1023];

  bit          ident_u = 1'b0;
  int          lat_u = 4;
  int          remain = 0;
  int          starts = 0;
  logic [31:0] din_cap = 32'h0;

  int n_cmp = 0;
  int n_bad = 0;

  bench_sequencer #(.DATA_W(32), .CNT_W(32), .DEFAULT_ITER(5)) u_dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .dut_start(dut_start), .dut_din(dut_din), .dut_dout(dut_dout),
    .dut_done(dut_done), .led(led)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compute unit: done is sampled by the sequencer lat_u edges after the edge launching dut_start.
  always @(posedge clk) begin
    dut_done <= 1'b0;
    if (rst) begin
      remain <= 0;
    end else if (dut_start) begin
      starts  <= starts + 1;
      din_cap <= dut_din;
      if (lat_u <= 2) begin
        dut_done <= 1'b1;
        dut_dout <= ident_u ? dut_din : (dut_din << 1);
      end else begin
        remain <= lat_u - 2;
      end
    end else if (remain > 0) begin
      remain <= remain - 1;
      if (remain == 1) begin
        dut_done <= 1'b1;
        dut_dout <= ident_u ? din_cap : (din_cap << 1);
        check("din_hold", dut_din, din_cap);
      end
    end
  end

  // UART transmitter: busy one cycle after tx_start, for a random 1..4 cycles.
  always @(posedge clk) begin
    if (rst) begin
      tx_act  <= 1'b0;
      tx_left <= 0;
    end else if (tx_start) begin
      tx_act            <= 1'b1;
      tx_left           <= $urandom_range(1, 4);
      txlog[tx_total]   <= tx_data;
      tx_total          <= tx_total + 1;
    end else if (tx_left > 0) begin
      tx_left <= tx_left - 1;
      if (tx_left == 1) tx_act <= 1'b0;
    end
  end

  assign tx_busy = hold_busy | tx_act;

  function automatic logic [63:0] model(input logic [31:0] seed, input int n);
    logic [31:0] a;
    longint      c;
    a = seed;
    for (int i = 0; i < n; i++) a = (ident_u ? a : (a << 1)) + 32'd1;
    c = longint'(n) * longint'(lat_u + 1) + 1;
    if (c > 64'h0000_0000_FFFF_FFFF) c = 64'h0000_0000_FFFF_FFFF;
    return {c[31:0], a};
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic set_limit(input logic [31:0] n);
    send_byte(8'h4E);
    for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8]);
  endtask

  task automatic send_seed(input logic [31:0] s);
    send_byte(8'h53);
    for (int i = 0; i < 4; i++) send_byte(s[8*i +: 8]);
  endtask

  task automatic collect(input string tag, input int base);
    int cyc;
    cyc = 0;
    while ((tx_total - base) < RESP_B && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_timeout"}, 64'((tx_total - base) >= RESP_B), 64'd1);
    cyc = 0;
    while (tx_busy && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic do_run(input string tag, input logic [31:0] seed, input int n,
                        input int hold, input logic [7:0] junk0, input logic [7:0] junk1,
                        input bit send_junk);
    logic [63:0] exp;
    int base, s0;
    exp  = model(seed, n);
    base = tx_total;
    s0   = starts;
    if (hold > 0) hold_busy = 1'b1;
    send_seed(seed);
    if (send_junk) begin
      @(negedge clk);
      send_byte(junk0);
      send_byte(junk1);
    end
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      check({tag, "_held_tx"}, 64'(tx_total - base), 64'd0);
      check({tag, "_held_led"}, 64'(led), 64'd0);
      hold_busy = 1'b0;
    end
    collect(tag, base);
    for (int i = 0; i < RESP_B; i++)
      check($sformatf("%s_byte%0d", tag, i), 64'(txlog[base + i]), 64'(exp[8*i +: 8]));
    check({tag, "_starts"}, 64'(starts - s0), 64'(n));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] seed;
    int n, base, s0;

    repeat (2) @(negedge clk);
    check("rst_led", 64'(led), 64'd0);
    check("rst_tx_start", 64'(tx_start), 64'd0);
    check("rst_dut_start", 64'(dut_start), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_tx_data", 64'(tx_data), 64'd0);
    check("post_rst_dut_din", 64'(dut_din), 64'd0);
    check("post_rst_led", 64'(led), 64'd0);

    // Doubling unit, L=4, N=3, seed 1: 1->3->7->15, 16 cycles.
    send_byte(8'h7F);
    ident_u = 1'b0; lat_u = 4;
    set_limit(32'd3);
    do_run("double_n3", 32'h0000_0001, 3, 0, 8'h0, 8'h0, 1'b0);

    set_limit(32'd0);
    do_run("n_zero", 32'hDDCC_BBAA, 0, 0, 8'h0, 8'h0, 1'b0);

    ident_u = 1'b1; lat_u = 3;
    set_limit(32'd1);
    do_run("wrap", 32'hFFFF_FFFF, 1, 0, 8'h0, 8'h0, 1'b0);

    ident_u = 1'b0; lat_u = 8;
    set_limit(32'd2);
    do_run("drop_in_wait", 32'h1234_5678, 2, 0, 8'h53, 8'h11, 1'b1);
    do_run("after_drop", 32'h0BAD_F00D, 2, 0, 8'h0, 8'h0, 1'b0);

    lat_u = 2;
    set_limit(32'd1);
    do_run("busy_hold", 32'h0000_00A5, 1, 50, 8'h0, 8'h0, 1'b0);

    // Reset mid-WAIT, then mid-ARG; the default limit of 5 must be back.
    ident_u = 1'b1; lat_u = 4;
    set_limit(32'd7);
    send_seed(32'h0000_0100);
    repeat (3) @(negedge clk);
    check("pre_rst_led", 64'(led), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_wait_led", 64'(led), 64'd0);
    check("rst_wait_tx_start", 64'(tx_start), 64'd0);
    check("rst_wait_dut_din", 64'(dut_din), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    send_byte(8'h4E);
    send_byte(8'h02);
    send_byte(8'h00);
    rst = 1'b1;
    @(negedge clk);
    check("rst_arg_led", 64'(led), 64'd0);
    check("rst_arg_tx_start", 64'(tx_start), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    do_run("default_iter", 32'h0000_1000, 5, 0, 8'h0, 8'h0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      seed    = $urandom;
      n       = $urandom_range(0, 6);
      lat_u   = $urandom_range(2, 6);
      ident_u = 1'($urandom_range(0, 1));
      set_limit(32'(n));
      do_run($sformatf("rand%0d", r), seed, n, 0, 8'h0, 8'h0, 1'b0);
    end

    // No spontaneous output while idle.
    base = tx_total;
    s0   = starts;
    repeat (20) @(negedge clk);
    check("idle_quiet_tx", 64'(tx_total - base), 64'd0);
    check("idle_quiet_start", 64'(starts - s0), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
